// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, opcode encodings and divider state codes for the execute stage
package ex_stage_pkg;

  localparam int XLEN     = 32;
  localparam int DIV_ITER = 32;                 // one quotient bit per cycle, equals XLEN
  localparam int CNT_W    = $clog2(DIV_ITER);

  // Value of a ctrl stall bit that freezes the corresponding stage
  localparam logic STOP = 1'b1;

  // Result class (alusel)
  localparam logic [2:0] EXE_RES_NOP    = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC  = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT  = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH  = 3'b011;
  localparam logic [2:0] EXE_RES_JUMP   = 3'b100;
  localparam logic [2:0] EXE_RES_MULDIV = 3'b101;

  // Operation (aluop)
  localparam logic [7:0] EXE_NOP_OP    = 8'h00;
  localparam logic [7:0] EXE_AND_OP    = 8'h01;
  localparam logic [7:0] EXE_OR_OP     = 8'h02;
  localparam logic [7:0] EXE_XOR_OP    = 8'h03;
  localparam logic [7:0] EXE_SLL_OP    = 8'h04;
  localparam logic [7:0] EXE_SRL_OP    = 8'h05;
  localparam logic [7:0] EXE_SRA_OP    = 8'h06;
  localparam logic [7:0] EXE_ADD_OP    = 8'h07;
  localparam logic [7:0] EXE_SUB_OP    = 8'h08;
  localparam logic [7:0] EXE_SLT_OP    = 8'h09;
  localparam logic [7:0] EXE_SLTU_OP   = 8'h0A;
  localparam logic [7:0] EXE_JAL_OP    = 8'h0B;
  localparam logic [7:0] EXE_MUL_OP    = 8'h10;
  localparam logic [7:0] EXE_MULH_OP   = 8'h11;
  localparam logic [7:0] EXE_MULHSU_OP = 8'h12;
  localparam logic [7:0] EXE_MULHU_OP  = 8'h13;
  localparam logic [7:0] EXE_DIV_OP    = 8'h14;
  localparam logic [7:0] EXE_DIVU_OP   = 8'h15;
  localparam logic [7:0] EXE_REM_OP    = 8'h16;
  localparam logic [7:0] EXE_REMU_OP   = 8'h17;

  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_END  = 2'b10
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
           (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - id_ex -> ex -> ex_mem signal bundle
//   master: id_ex/ctrl side, drives operands, control and stall bus
//   slave : execute stage, drives write-back fields and stall request
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [5:0]      stall;
  logic [7:0]      aluop_i;
  logic [2:0]      alusel_i;
  logic [XLEN-1:0] reg1_i;
  logic [XLEN-1:0] reg2_i;
  logic            wreg_i;
  logic [4:0]      wd_i;
  logic [XLEN-1:0] link_addr_i;

  logic            wreg_o;
  logic [4:0]      wd_o;
  logic [XLEN-1:0] wdata_o;
  logic            stallreq_o;

  modport master (
    output stall, aluop_i, alusel_i, reg1_i, reg2_i, wreg_i, wd_i, link_addr_i,
    input  wreg_o, wd_o, wdata_o, stallreq_o
  );

  modport slave (
    input  stall, aluop_i, alusel_i, reg1_i, reg2_i, wreg_i, wd_i, link_addr_i,
    output wreg_o, wd_o, wdata_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage_div.sv
// rtl/ex_stage_div.sv - iterative radix-2 restoring divider (module div_unit)
//   clk, annul      : clock, synchronous abort/reset (active-high)
//   start           : div-class op present while idle
//   signed_op       : DIV/REM (vs DIVU/REMU)
//   hold            : EX result not consumed, keep the result in DIV_END
//   opa, opb        : dividend, divisor
//   result_q/_r     : sign-corrected quotient / remainder, valid while ready
//   ready           : result available (DIV_END)
//   busy            : stall request (accepting a start, or iterating)
module div_unit
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            annul,
  input  logic            start,
  input  logic            signed_op,
  input  logic            hold,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] result_q,
  output logic [XLEN-1:0] result_r,
  output logic            ready,
  output logic            busy
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [2*XLEN-1:0] dvd, dvd_next;    // {partial remainder, dividend/quotient bits}
  logic [XLEN-1:0]   dvs, dvs_next;
  logic              neg_q, neg_q_next, neg_r, neg_r_next;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     partial;          // remainder shifted left with the next dividend bit
  logic [XLEN-1:0]   diff;

  assign sign_a  = signed_op & opa[XLEN-1];
  assign sign_b  = signed_op & opb[XLEN-1];
  assign mag_a   = sign_a ? -opa : opa;
  assign mag_b   = sign_b ? -opb : opb;
  assign partial = dvd[2*XLEN-1:XLEN-1];
  // partial < 2*dvs whenever it is subtracted, so the low XLEN bits are exact
  assign diff    = partial[XLEN-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (annul) begin
      state <= DIV_FREE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      dvd   <= dvd_next;
      dvs   <= dvs_next;
      neg_q <= neg_q_next;
      neg_r <= neg_r_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dvd_next   = dvd;
    dvs_next   = dvs;
    neg_q_next = neg_q;
    neg_r_next = neg_r;
    case (state)
      DIV_FREE: begin
        if (start) begin
          cnt_next   = '0;
          neg_q_next = 1'b0;
          neg_r_next = 1'b0;
          if (opb == '0) begin
            // Result is preloaded so DIV_END needs no special handling
            dvd_next   = {opa, {XLEN{1'b1}}};
            state_next = DIV_END;
          end else if (signed_op && (opa == INT_MIN) && (opb == {XLEN{1'b1}})) begin
            dvd_next   = {{XLEN{1'b0}}, INT_MIN};
            state_next = DIV_END;
          end else begin
            dvd_next   = {{XLEN{1'b0}}, mag_a};
            dvs_next   = mag_b;
            neg_q_next = sign_a ^ sign_b;
            neg_r_next = sign_a;
            state_next = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (partial >= {1'b0, dvs}) begin
          dvd_next = {diff, dvd[XLEN-2:0], 1'b1};
        end else begin
          dvd_next = {partial[XLEN-1:0], dvd[XLEN-2:0], 1'b0};
        end
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(DIV_ITER - 1)) begin
          state_next = DIV_END;
        end
      end
      DIV_END: begin
        if (!hold) begin
          state_next = DIV_FREE;
        end
      end
      default: state_next = DIV_FREE;
    endcase
  end

  assign result_q = neg_q ? -dvd[XLEN-1:0]      : dvd[XLEN-1:0];
  assign result_r = neg_r ? -dvd[2*XLEN-1:XLEN] : dvd[2*XLEN-1:XLEN];
  assign ready    = (state == DIV_END);
  assign busy     = ((state == DIV_FREE) && start) || (state == DIV_BUSY);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32IM execute stage: single-cycle ALU/MUL plus iterative divider
//   clk, rst : clock, synchronous active-high reset
//   ex       : ex_stage_if.slave - id_ex operands/control and stall bus in,
//              ex_mem write-back fields and stall request out
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ex
);

  logic            div_start, div_signed, div_ready, div_busy;
  logic [XLEN-1:0] div_q, div_r;
  logic [XLEN-1:0] alu_res;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic            unused_stall;

  // Only the EX stall bit matters here
  assign unused_stall = ^{ex.stall[5:4], ex.stall[2:0]};

  assign div_start  = (ex.alusel_i == EXE_RES_MULDIV) && is_div_op(ex.aluop_i);
  assign div_signed = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_REM_OP);

  div_unit u_div (
    .clk       (clk),
    .annul     (rst),
    .start     (div_start),
    .signed_op (div_signed),
    .hold      (ex.stall[3] == STOP),
    .opa       (ex.reg1_i),
    .opb       (ex.reg2_i),
    .result_q  (div_q),
    .result_r  (div_r),
    .ready     (div_ready),
    .busy      (div_busy)
  );

  // One 64-bit multiplier; operand extension picks the signedness.
  // The low half is identical for every extension, so MUL shares it.
  assign mul_a = (ex.aluop_i == EXE_MULHU_OP) ? {{XLEN{1'b0}}, ex.reg1_i}
                                              : {{XLEN{ex.reg1_i[XLEN-1]}}, ex.reg1_i};
  assign mul_b = ((ex.aluop_i == EXE_MULHSU_OP) || (ex.aluop_i == EXE_MULHU_OP))
                 ? {{XLEN{1'b0}}, ex.reg2_i}
                 : {{XLEN{ex.reg2_i[XLEN-1]}}, ex.reg2_i};
  assign prod  = mul_a * mul_b;

  always_comb begin
    alu_res = '0;
    case (ex.alusel_i)
      EXE_RES_LOGIC: begin
        case (ex.aluop_i)
          EXE_AND_OP: alu_res = ex.reg1_i & ex.reg2_i;
          EXE_OR_OP:  alu_res = ex.reg1_i | ex.reg2_i;
          EXE_XOR_OP: alu_res = ex.reg1_i ^ ex.reg2_i;
          default:    alu_res = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (ex.aluop_i)
          EXE_SLL_OP: alu_res = ex.reg1_i << ex.reg2_i[4:0];
          EXE_SRL_OP: alu_res = ex.reg1_i >> ex.reg2_i[4:0];
          EXE_SRA_OP: alu_res = $unsigned($signed(ex.reg1_i) >>> ex.reg2_i[4:0]);
          default:    alu_res = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (ex.aluop_i)
          EXE_ADD_OP:  alu_res = ex.reg1_i + ex.reg2_i;
          EXE_SUB_OP:  alu_res = ex.reg1_i - ex.reg2_i;
          EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
          EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, ex.reg1_i < ex.reg2_i};
          default:     alu_res = '0;
        endcase
      end
      EXE_RES_JUMP: alu_res = ex.link_addr_i;
      EXE_RES_MULDIV: begin
        case (ex.aluop_i)
          EXE_MUL_OP:                alu_res = prod[XLEN-1:0];
          EXE_MULH_OP, EXE_MULHSU_OP,
          EXE_MULHU_OP:              alu_res = prod[2*XLEN-1:XLEN];
          EXE_DIV_OP, EXE_DIVU_OP:   alu_res = div_ready ? div_q : '0;
          EXE_REM_OP, EXE_REMU_OP:   alu_res = div_ready ? div_r : '0;
          default:                   alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Write-back is suppressed while stalling so ID never forwards a partial result
  always_comb begin
    ex.stallreq_o = 1'b0;
    ex.wreg_o     = 1'b0;
    ex.wd_o       = '0;
    ex.wdata_o    = '0;
    if (!rst) begin
      ex.stallreq_o = div_busy;
      ex.wreg_o     = ex.wreg_i & ~div_busy;
      ex.wd_o       = ex.wd_i;
      ex.wdata_o    = alu_res;
    end
  end

endmodule
